// File: rtl/pool_pkg.sv
// Shared types for the activation-map writer and the pooling window
// controller.
//   ACT_DATA_W  : activation sample width
//   act_t       : signed activation sample
//   wr_st_t     : frame writer states
//   relu_clamp  : optional ReLU applied to a sample before it is stored
package pool_pkg;

  localparam int ACT_DATA_W = 16;

  typedef logic signed [ACT_DATA_W-1:0] act_t;

  typedef enum logic [1:0] {
    FILL,
    HANDOFF,
    LOCKED
  } wr_st_t;

  // Negative samples become zero when enabled; otherwise the sample passes through.
  function automatic act_t relu_clamp(input act_t x, input logic en);
    return (en && (x < 0)) ? act_t'(0) : x;
  endfunction

endpackage

// File: rtl/act_map_frame_writer.sv
// Fills the activation frame buffer read by the pooling window controller.
// A raster-order stream of signed samples is accepted over valid/ready and
// written into a flat ACT_W*ACT_H buffer. Once the frame is complete, start
// pulses for one cycle. The buffer then stays locked until pool_done.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_data    activation sample (sampled only on accept)
//   in_valid   in_data is valid
//   in_ready   writer accepts a sample this cycle (decoded from state)
//   in_last    producer's end-of-frame marker, qualified by accept
//   act_map    frame buffer, index = row*ACT_W + col
//   start      one-cycle pulse: frame complete, pooler may begin
//   pool_done  pooler finished with the current frame (honoured only in LOCKED)
//   frame_err  one-cycle pulse when in_last disagrees with the pixel count
//   frame_cnt  number of frames handed off, wraps at 2^16
module act_map_frame_writer
  import pool_pkg::*;
#(
  parameter int   ACT_W   = 26,
  parameter int   ACT_H   = 26,
  parameter logic RELU_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  act_t        in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output act_t        act_map [0:ACT_W*ACT_H-1],
  output logic        start,
  input  logic        pool_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam int               N        = ACT_W * ACT_H;
  localparam int               IDX_W    = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  wr_st_t           state;
  wr_st_t           state_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic             accept;
  logic             at_end;

  // These outputs decode only the state register. They have no path from in_*.
  assign in_ready = (state == FILL);
  assign start    = (state == HANDOFF);
  assign accept   = in_valid && in_ready;
  assign at_end   = (wr_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= FILL;
    else          state <= state_nxt;
  end

  // NOTE: default first so every path assigns state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && at_end) state_nxt = HANDOFF;
      HANDOFF: state_nxt = LOCKED;       // pool_done is ignored here
      LOCKED:  if (pool_done) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_idx    <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      // NOTE: the buffer is a visible output and must read as zero after reset.
      // That makes it a flop array with reset, not a RAM.
      for (int i = 0; i < N; i++) act_map[i] <= '0;
    end else begin
      // Error when in_last disagrees with the pixel count: an early last, or a
      // missing last on the final pixel. The count decides when the frame ends.
      frame_err <= accept && (in_last ^ at_end);
      if (accept) begin
        act_map[wr_idx] <= relu_clamp(in_data, RELU_EN);
        // An early last discards the partial frame. The next frame overwrites it from index 0.
        wr_idx <= (at_end || in_last) ? '0 : wr_idx + 1'b1;
      end
      if (state == HANDOFF) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_act_map_frame_writer.sv
// Scoreboard bench for act_map_frame_writer on a 4x4 frame. Two instances
// receive the same stimulus: dut0 has ReLU off and dut1 has ReLU on. The
// stimulus pushes the expected start/frame_err events and frame contents.
// A monitor pops and compares one entry whenever either pulse appears.
module tb_act_map_frame_writer;
  import pool_pkg::*;

  localparam int N = 16;

  typedef struct packed {
    logic           start;
    logic           err;
    logic [15:0]    cnt;    // frame_cnt expected while start is high
    logic [N*16-1:0] raw;   // expected buffer, ReLU off
    logic [N*16-1:0] relu;  // expected buffer, ReLU on
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  act_t        in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        pool_done = 1'b0;

  logic        in_ready0, in_ready1;
  act_t        act_map0 [0:N-1];
  act_t        act_map1 [0:N-1];
  logic        start0, start1, err0, err1;
  logic [15:0] frame_cnt0, frame_cnt1;

  int          n_pass  = 0;
  int          n_total = 0;
  exp_t        sb_q[$];

  logic [N*16-1:0] m_raw, m_relu;
  int              m_idx;
  logic [15:0]     m_cnt;

  act_map_frame_writer #(.ACT_W(4), .ACT_H(4), .RELU_EN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .in_last(in_last), .act_map(act_map0),
    .start(start0), .pool_done(pool_done), .frame_err(err0),
    .frame_cnt(frame_cnt0)
  );

  act_map_frame_writer #(.ACT_W(4), .ACT_H(4), .RELU_EN(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .in_last(in_last), .act_map(act_map1),
    .start(start1), .pool_done(pool_done), .frame_err(err1),
    .frame_cnt(frame_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N*16-1:0] act,
                       input logic [N*16-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [N*16-1:0] pack(input act_t m [0:N-1]);
    logic [N*16-1:0] v;
    for (int i = 0; i < N; i++) v[i*16 +: 16] = m[i];
    return v;
  endfunction

  // Monitor: every start or frame_err pulse must match the next expected event.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (start0 || start1 || err0 || err1) begin
      if (sb_q.size() == 0) begin
        check("unexpected start/frame_err", {start1, err1}, 0);
      end else begin
        e = sb_q.pop_front();
        check("start dut0", start0, e.start);
        check("start dut1", start1, e.start);
        check("frame_err dut0", err0, e.err);
        check("frame_err dut1", err1, e.err);
        if (e.start) begin
          check("frame_cnt at start", frame_cnt1, e.cnt);
          check("frame relu off", pack(act_map0), e.raw);
          check("frame relu on", pack(act_map1), e.relu);
        end
      end
    end
  end

  // Offer one sample and wait for it to be accepted. Entered and left at posedge+1.
  task automatic send(input act_t d, input logic last);
    int budget = 50;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready1 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) begin
      check("in_ready timeout", in_ready1, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    // Reference model of the accepted sample
    m_raw[m_idx*16 +: 16]  = d;
    m_relu[m_idx*16 +: 16] = (d < 0) ? act_t'(0) : d;
    if (m_idx == N - 1) begin
      sb_q.push_back('{start: 1'b1, err: !last, cnt: m_cnt, raw: m_raw, relu: m_relu});
      m_cnt++;
      m_idx = 0;
      check("start one cycle after last accept", start1, 1'b1);
    end else if (last) begin
      sb_q.push_back('{start: 1'b0, err: 1'b1, cnt: m_cnt, raw: m_raw, relu: m_relu});
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Called in the HANDOFF cycle. Moves through LOCKED and releases with pool_done.
  task automatic release_lock();
    @(posedge clk); #1;
    check("in_ready low in LOCKED", in_ready1, 1'b0);
    pool_done = 1'b1;
    @(posedge clk); #1;
    pool_done = 1'b0;
    check("in_ready after pool_done", {in_ready0, in_ready1}, 2'b11);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_raw  = '0;
    m_relu = '0;
    m_idx  = 0;
    m_cnt  = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [N*16-1:0] held;
    m_raw = '0; m_relu = '0; m_idx = 0; m_cnt = '0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    check("reset in_ready", {in_ready0, in_ready1}, 2'b11);
    check("reset start/err", {start0, start1, err0, err1}, 4'b0);
    check("reset frame_cnt", {frame_cnt0, frame_cnt1}, 32'd0);
    check("reset act_map", pack(act_map0) | pack(act_map1), '0);

    // Frame A: 0..15 with last on 15. pool_done in HANDOFF must be ignored.
    for (int i = 0; i < N; i++) send(act_t'(i), i == N - 1);
    pool_done = 1'b1;                        // coincides with start
    @(posedge clk); #1;
    pool_done = 1'b0;
    check("start is one cycle", start1, 1'b0);
    check("pool_done in HANDOFF ignored", in_ready1, 1'b0);
    check("frame_cnt after frame A", {frame_cnt0, frame_cnt1}, {16'd1, 16'd1});
    // Apply backpressure in LOCKED: the writer stays blocked and the buffer holds.
    held = pack(act_map0);
    in_valid = 1'b1;
    in_data  = 16'sh7FFF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("in_ready low under backpressure", {in_ready0, in_ready1}, 2'b00);
    end
    in_valid = 1'b0;
    check("act_map stable in LOCKED", pack(act_map0), held);
    check("act_map relu stable in LOCKED", pack(act_map1), held);
    pool_done = 1'b1;
    @(posedge clk); #1;
    pool_done = 1'b0;
    check("in_ready after pool_done", {in_ready0, in_ready1}, 2'b11);

    // Frame B alternates -5 and +7, and ends with the two extremes.
    for (int i = 0; i < N; i++) begin
      act_t d;
      if (i == 14)      d = -16'sd32768;
      else if (i == 15) d = 16'sd32767;
      else              d = (i % 2 == 0) ? -16'sd5 : 16'sd7;
      send(d, i == N - 1);
    end
    release_lock();

    // Early last on sample 9, then a full frame 100..115
    for (int i = 0; i < 10; i++) send(act_t'(50 + i), i == 9);
    check("no start after early last", start1, 1'b0);
    for (int i = 0; i < N; i++) send(act_t'(100 + i), i == N - 1);
    release_lock();

    // Missing last: frame_err and start arrive in the same cycle.
    for (int i = 0; i < N; i++) send(act_t'(200 - 30 * i), 1'b0);
    release_lock();
    check("frame_cnt after 4 frames", frame_cnt1, 16'd4);

    // Reset mid-frame
    for (int i = 0; i < 6; i++) send(act_t'(-i - 1), 1'b0);
    do_reset();
    check("mid-frame reset clears buffer", pack(act_map0) | pack(act_map1), '0);
    check("mid-frame reset frame_cnt", frame_cnt1, 16'd0);
    check("mid-frame reset outputs", {in_ready1, start1, err1}, 3'b100);
    for (int i = 0; i < N; i++) send(act_t'(3 * i - 20), i == N - 1);
    release_lock();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
